// File: rtl/hazard_pipeline_controller.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_pipeline_controller
//  Purpose  : Control-side sequencer for the 5-stage RV32 pipe. It carries the
//             decoded control bits through ID/EX, EX/MEM and MEM/WB. It also
//             generates stall, flush and forwarding selects, freezes the pipe
//             while data memory is busy, and flags a memory port that never
//             answers.
//  Ports    : clk, rst              - clock, synchronous active-high reset
//             *D                    - ID-stage decoded control and addresses
//             ZeroE                 - ALU zero flag from EX
//             MemReady              - data memory completes the M access
//             *E / *M / *W          - stage control registers
//             PCSrcE                - branch taken
//             StallF/D/X, FlushD/E  - hazard controls
//             ForwardAE/BE          - operand bypass selects
//                                     (00 regfile, 10 from M, 01 from W)
//             MemErr                - sticky memory-timeout flag
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_pipeline_controller #(
  parameter int REG_AW   = 5,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteD,
  input  logic              ResultSrcD,
  input  logic              MemWriteD,
  input  logic              BranchD,
  input  logic              ALUSrcD,
  input  logic [2:0]        ALUControlD,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] RdD,
  input  logic              ZeroE,
  input  logic              MemReady,
  output logic              RegWriteE,
  output logic              ResultSrcE,
  output logic              MemWriteE,
  output logic              BranchE,
  output logic              ALUSrcE,
  output logic [2:0]        ALUControlE,
  output logic [REG_AW-1:0] Rs1E,
  output logic [REG_AW-1:0] Rs2E,
  output logic [REG_AW-1:0] RdE,
  output logic              RegWriteM,
  output logic              ResultSrcM,
  output logic              MemWriteM,
  output logic [REG_AW-1:0] RdM,
  output logic              RegWriteW,
  output logic              ResultSrcW,
  output logic [REG_AW-1:0] RdW,
  output logic              PCSrcE,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              FlushE,
  output logic              StallX,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              MemErr
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  logic             mem_wait;
  logic             load_use;
  logic [CNT_W-1:0] wait_cnt;

  // Hazard detection and forwarding
  always_comb begin
    PCSrcE    = BranchE & ZeroE;
    // Only a real load/store in M can wait; a bubble never stalls the pipe.
    mem_wait  = (MemWriteM | ResultSrcM) & ~MemReady & (RegWriteM | MemWriteM);
    load_use  = ResultSrcE & (RdE != '0) & ((RdE == Rs1D) | (RdE == Rs2D));

    StallF    = 1'b0;
    StallD    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    StallX    = mem_wait;

    if (mem_wait) begin
      // Whole pipe frozen; a pending branch resolves once memory answers.
      StallF = 1'b1;
      StallD = 1'b1;
    end else if (PCSrcE) begin
      // The ID instruction is discarded, so a load-use stall on it is moot.
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (load_use) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end

    // M stage is the younger producer, so it wins over W.
    ForwardAE = 2'b00;
    if (RegWriteM && (RdM != '0) && (RdM == Rs1E))      ForwardAE = 2'b10;
    else if (RegWriteW && (RdW != '0) && (RdW == Rs1E)) ForwardAE = 2'b01;

    ForwardBE = 2'b00;
    if (RegWriteM && (RdM != '0) && (RdM == Rs2E))      ForwardBE = 2'b10;
    else if (RegWriteW && (RdW != '0) && (RdW == Rs2E)) ForwardBE = 2'b01;
  end

  // ID/EX control register
  always_ff @(posedge clk) begin
    if (rst || (!StallX && FlushE)) begin
      RegWriteE   <= 1'b0;
      ResultSrcE  <= 1'b0;
      MemWriteE   <= 1'b0;
      BranchE     <= 1'b0;
      ALUSrcE     <= 1'b0;
      ALUControlE <= 3'b000;
      Rs1E        <= '0;
      Rs2E        <= '0;
      RdE         <= '0;
    end else if (!StallX) begin
      RegWriteE   <= RegWriteD;
      ResultSrcE  <= ResultSrcD;
      MemWriteE   <= MemWriteD;
      BranchE     <= BranchD;
      ALUSrcE     <= ALUSrcD;
      ALUControlE <= ALUControlD;
      Rs1E        <= Rs1D;
      Rs2E        <= Rs2D;
      RdE         <= RdD;
    end
  end

  // EX/MEM control register
  always_ff @(posedge clk) begin
    if (rst) begin
      RegWriteM  <= 1'b0;
      ResultSrcM <= 1'b0;
      MemWriteM  <= 1'b0;
      RdM        <= '0;
    end else if (!StallX) begin
      RegWriteM  <= RegWriteE;
      ResultSrcM <= ResultSrcE;
      MemWriteM  <= MemWriteE;
      RdM        <= RdE;
    end
  end

  // MEM/WB control register; a bubble enters WB while M is waiting so the
  // stalled access is written back exactly once, after it completes.
  always_ff @(posedge clk) begin
    if (rst || mem_wait) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= 1'b0;
      RdW        <= '0;
    end else begin
      RegWriteW  <= RegWriteM;
      ResultSrcW <= ResultSrcM;
      RdW        <= RdM;
    end
  end

  // Memory timeout watchdog: counts consecutive wait cycles, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      MemErr   <= 1'b0;
    end else if (mem_wait) begin
      if (wait_cnt == CNT_W'(MAX_WAIT)) begin
        MemErr <= 1'b1;
      end else begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
    end else begin
      wait_cnt <= '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_pipeline_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_pipeline_controller
//  Purpose  : Self-checking bench for hazard_pipeline_controller. Each cycle the
//             stimulus pushes the outputs it expects onto a scoreboard queue;
//             the queue is drained and compared on the falling edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_pipeline_controller;

  localparam int REG_AW   = 5;
  localparam int MAX_WAIT = 15;

  localparam int S_RWE = 0,  S_RSE = 1,  S_BRE = 2,  S_ALUE = 3,  S_RDE = 4;
  localparam int S_RS1E = 5, S_RWM = 6,  S_RSM = 7,  S_RDM = 8,   S_RWW = 9;
  localparam int S_RSW = 10, S_RDW = 11, S_PCS = 12, S_STF = 13,  S_STD = 14;
  localparam int S_FLD = 15, S_FLE = 16, S_STX = 17, S_FWA = 18,  S_FWB = 19;
  localparam int S_ERR = 20;

  logic              clk = 1'b0;
  logic              rst;
  logic              RegWriteD, ResultSrcD, MemWriteD, BranchD, ALUSrcD;
  logic [2:0]        ALUControlD;
  logic [REG_AW-1:0] Rs1D, Rs2D, RdD;
  logic              ZeroE, MemReady;
  logic              RegWriteE, ResultSrcE, MemWriteE, BranchE, ALUSrcE;
  logic [2:0]        ALUControlE;
  logic [REG_AW-1:0] Rs1E, Rs2E, RdE;
  logic              RegWriteM, ResultSrcM, MemWriteM;
  logic [REG_AW-1:0] RdM;
  logic              RegWriteW, ResultSrcW;
  logic [REG_AW-1:0] RdW;
  logic              PCSrcE, StallF, StallD, FlushD, FlushE, StallX;
  logic [1:0]        ForwardAE, ForwardBE;
  logic              MemErr;

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  hazard_pipeline_controller #(.REG_AW(REG_AW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .MemWriteD(MemWriteD),
    .BranchD(BranchD), .ALUSrcD(ALUSrcD), .ALUControlD(ALUControlD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .ZeroE(ZeroE), .MemReady(MemReady),
    .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
    .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
    .RdM(RdM),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RdW(RdW),
    .PCSrcE(PCSrcE), .StallF(StallF), .StallD(StallD),
    .FlushD(FlushD), .FlushE(FlushE), .StallX(StallX),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .MemErr(MemErr)
  );

  task automatic check(input string tag, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [31:0] obs(input int sig);
    case (sig)
      S_RWE:   obs = 32'(RegWriteE);
      S_RSE:   obs = 32'(ResultSrcE);
      S_BRE:   obs = 32'(BranchE);
      S_ALUE:  obs = 32'(ALUControlE);
      S_RDE:   obs = 32'(RdE);
      S_RS1E:  obs = 32'(Rs1E);
      S_RWM:   obs = 32'(RegWriteM);
      S_RSM:   obs = 32'(ResultSrcM);
      S_RDM:   obs = 32'(RdM);
      S_RWW:   obs = 32'(RegWriteW);
      S_RSW:   obs = 32'(ResultSrcW);
      S_RDW:   obs = 32'(RdW);
      S_PCS:   obs = 32'(PCSrcE);
      S_STF:   obs = 32'(StallF);
      S_STD:   obs = 32'(StallD);
      S_FLD:   obs = 32'(FlushD);
      S_FLE:   obs = 32'(FlushE);
      S_STX:   obs = 32'(StallX);
      S_FWA:   obs = 32'(ForwardAE);
      S_FWB:   obs = 32'(ForwardBE);
      S_ERR:   obs = 32'(MemErr);
      default: obs = 32'hDEAD_BEEF;
    endcase
  endfunction

  // Push an expectation for the current cycle.
  task automatic ex(input string tag, input int sig, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.val = val;
    sb.push_back(e);
  endtask

  // Compare everything queued for this cycle, then advance one clock edge.
  task automatic cyc();
    exp_t e;
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, obs(e.sig), e.val);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clr_d();
    RegWriteD = 1'b0; ResultSrcD = 1'b0; MemWriteD = 1'b0; BranchD = 1'b0;
    ALUSrcD = 1'b0; ALUControlD = 3'b000; Rs1D = '0; Rs2D = '0; RdD = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; clr_d(); ZeroE = 1'b0; MemReady = 1'b1;
    @(posedge clk); #1;

    // Reset state
    ex("rst_RegWriteE", S_RWE, 0); ex("rst_RdE", S_RDE, 0);
    ex("rst_RegWriteM", S_RWM, 0); ex("rst_RdM", S_RDM, 0);
    ex("rst_RegWriteW", S_RWW, 0); ex("rst_MemErr", S_ERR, 0);
    ex("rst_StallF", S_STF, 0);    ex("rst_StallX", S_STX, 0);
    ex("rst_FlushE", S_FLE, 0);    ex("rst_ForwardAE", S_FWA, 0);
    cyc();
    rst = 1'b0;

    // Walk an ALU op through E, M, W
    RegWriteD = 1'b1; RdD = 5; ALUControlD = 3'b010;
    ex("walk_StallF0", S_STF, 0); ex("walk_FlushD0", S_FLD, 0);
    cyc();
    clr_d();
    ex("walk_RegWriteE", S_RWE, 1); ex("walk_RdE", S_RDE, 5);
    ex("walk_ALUControlE", S_ALUE, 3'b010);
    ex("walk_StallF1", S_STF, 0); ex("walk_FlushE1", S_FLE, 0);
    cyc();
    ex("walk_RegWriteM", S_RWM, 1); ex("walk_RdM", S_RDM, 5);
    ex("walk_StallD2", S_STD, 0);
    cyc();
    ex("walk_RegWriteW", S_RWW, 1); ex("walk_RdW", S_RDW, 5);
    ex("walk_StallX3", S_STX, 0); ex("walk_FlushD3", S_FLD, 0);
    cyc();

    // Load-use: lw x6, then a consumer of x6
    RegWriteD = 1'b1; ResultSrcD = 1'b1; RdD = 6;
    cyc();
    clr_d(); RegWriteD = 1'b1; Rs1D = 6; Rs2D = 1; RdD = 7;
    ex("lu_StallF", S_STF, 1); ex("lu_StallD", S_STD, 1);
    ex("lu_FlushE", S_FLE, 1); ex("lu_FlushD", S_FLD, 0);
    cyc();
    ex("lu_bubble_StallF", S_STF, 0); ex("lu_bubble_FlushE", S_FLE, 0);
    ex("lu_bubble_RegWriteE", S_RWE, 0); ex("lu_bubble_RdE", S_RDE, 0);
    ex("lu_lw_RdM", S_RDM, 6); ex("lu_lw_ResultSrcM", S_RSM, 1);
    cyc();
    clr_d();
    ex("lu_Rs1E", S_RS1E, 6); ex("lu_ForwardAE", S_FWA, 2'b01);
    ex("lu_ForwardBE", S_FWB, 2'b00);
    cyc();

    // Forward priority: M beats W, then W alone when RdM=0
    for (int pass = 0; pass < 2; pass++) begin
      clr_d(); RegWriteD = 1'b1; RdD = 7;
      cyc();
      clr_d(); RegWriteD = 1'b1; RdD = (pass == 0) ? 5'd7 : 5'd0;
      cyc();
      clr_d(); Rs1D = 7; Rs2D = 7;
      cyc();
      clr_d();
      ex("fwd_ForwardAE", S_FWA, (pass == 0) ? 2'b10 : 2'b01);
      ex("fwd_ForwardBE", S_FWB, (pass == 0) ? 2'b10 : 2'b01);
      cyc();
    end

    // Branch taken while a load-use condition is present
    clr_d(); BranchD = 1'b1; ResultSrcD = 1'b1; RdD = 9;
    cyc();
    clr_d(); Rs1D = 9; ZeroE = 1'b1;
    ex("br_PCSrcE", S_PCS, 1); ex("br_FlushD", S_FLD, 1);
    ex("br_FlushE", S_FLE, 1); ex("br_StallF", S_STF, 0);
    ex("br_StallD", S_STD, 0);
    cyc();
    clr_d(); ZeroE = 1'b0;
    ex("br_after_BranchE", S_BRE, 0); ex("br_after_RdE", S_RDE, 0);
    cyc();

    // Memory wait: lw x10 in M, ALU op x11 in E, memory busy 3 cycles
    RegWriteD = 1'b1; ResultSrcD = 1'b1; RdD = 10;
    cyc();
    clr_d(); RegWriteD = 1'b1; RdD = 11;
    cyc();
    clr_d(); MemReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ex("mw_StallX", S_STX, 1); ex("mw_StallF", S_STF, 1);
      ex("mw_StallD", S_STD, 1); ex("mw_FlushE", S_FLE, 0);
      ex("mw_RegWriteW", S_RWW, 0);
      ex("mw_RdE_hold", S_RDE, 11); ex("mw_RdM_hold", S_RDM, 10);
      ex("mw_RegWriteM_hold", S_RWM, 1);
      cyc();
    end
    MemReady = 1'b1;
    ex("mw_ready_StallX", S_STX, 0); ex("mw_ready_RegWriteW", S_RWW, 0);
    cyc();
    ex("mw_post_RegWriteW", S_RWW, 1); ex("mw_post_RdW", S_RDW, 10);
    ex("mw_post_ResultSrcW", S_RSW, 1); ex("mw_post_RdM", S_RDM, 11);
    cyc();

    // Timeout: 17 consecutive wait cycles
    RegWriteD = 1'b1; ResultSrcD = 1'b1; RdD = 12;
    cyc();
    clr_d();
    cyc();
    MemReady = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      ex("to_MemErr", S_ERR, (i >= 17) ? 1 : 0);
      ex("to_StallX", S_STX, 1);
      cyc();
    end
    MemReady = 1'b1;
    ex("to_sticky_MemErr", S_ERR, 1); ex("to_release_StallX", S_STX, 0);
    cyc();
    ex("to_sticky2_MemErr", S_ERR, 1);
    cyc();

    // Reset in the middle of a wait
    RegWriteD = 1'b1; ResultSrcD = 1'b1; RdD = 13;
    cyc();
    clr_d();
    cyc();
    MemReady = 1'b0;
    ex("rw_StallX", S_STX, 1); ex("rw_MemErr", S_ERR, 1);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    ex("rw_MemErr_clr", S_ERR, 0);  ex("rw_RegWriteM", S_RWM, 0);
    ex("rw_RdM", S_RDM, 0);         ex("rw_RdE", S_RDE, 0);
    ex("rw_RegWriteW", S_RWW, 0);   ex("rw_RdW", S_RDW, 0);
    ex("rw_StallX", S_STX, 0);
    cyc();
    ex("rw_MemErr_stay0", S_ERR, 0);
    cyc();
    MemReady = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_pipeline_controller.md
Name: hazard_pipeline_controller

Overview:
Sequencing block for the 5-stage RV32 core. It sits between the ID-stage control decode and the datapath. It carries decoded control bits through the ID/EX, EX/MEM and MEM/WB control registers. It also generates stall, flush and forwarding selects, and holds the whole pipe while data memory is not ready. A timeout counter flags a memory port that never responds.

Parameters:
REG_AW, 5, register-address width (x0..x31)
MAX_WAIT, 15, max consecutive mem-not-ready cycles before MemErr; counter width = clog2(MAX_WAIT+1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
RegWriteD  in  1  decoded register-write enable
ResultSrcD  in  1  0 = ALU result, 1 = load data
MemWriteD  in  1  decoded store
BranchD  in  1  decoded branch
ALUSrcD  in  1  0 = rs2, 1 = immediate
ALUControlD  in  3  decoded ALU op
Rs1D, Rs2D, RdD  in  REG_AW each  ID-stage register addresses
ZeroE  in  1  ALU zero flag from EX
MemReady  in  1  data memory completes the current M-stage access this cycle
RegWriteE, ResultSrcE, MemWriteE, BranchE, ALUSrcE  out  1 each  EX-stage control
ALUControlE  out  3  EX-stage ALU op
Rs1E, Rs2E, RdE  out  REG_AW each  EX-stage addresses
RegWriteM, ResultSrcM, MemWriteM  out  1 each  MEM-stage control
RdM  out  REG_AW  MEM-stage destination
RegWriteW, ResultSrcW  out  1 each  WB-stage control
RdW  out  REG_AW  WB-stage destination
PCSrcE  out  1  branch taken: BranchE & ZeroE (combinational)
StallF, StallD  out  1 each  hold PC and IF/ID
FlushD, FlushE  out  1 each  bubble IF/ID and ID/EX
StallX  out  1  hold ID/EX, EX/MEM and datapath pipe registers (memory wait)
ForwardAE, ForwardBE  out  2 each  00 = regfile, 10 = from M, 01 = from W
MemErr  out  1  sticky memory-timeout flag

Behaviour:
- Reset: every registered output is 0 on the first clk edge with rst=1. This covers all E/M/W control, addresses, MemErr and the wait counter. Combinational outputs follow from the zeroed registers, so all stalls, flushes and forwards read 0. rst has priority over every other event.
- MemWait = (MemWriteM | ResultSrcM) & ~MemReady, gated by RegWriteM|MemWriteM so a bubble never waits.
- Priority is MemWait > branch taken > load-use.
- MemWait=1:
  - StallF, StallD and StallX are 1. ID/EX and EX/MEM hold.
  - MEM/WB loads a bubble: RegWriteW=0 and ResultSrcW=0.
  - FlushD and FlushE are 0, even if PCSrcE=1. The branch resolves after the wait.
- LoadUse = ResultSrcE & (RdE!=0) & (RdE==Rs1D | RdE==Rs2D).
- PCSrcE=1 and no MemWait:
  - FlushD=1 and FlushE=1.
  - StallF=0 and StallD=0, even if LoadUse. The ID instruction is discarded, so the stall is suppressed.
- LoadUse only (no MemWait, PCSrcE=0): StallF=1, StallD=1, FlushE=1. This inserts exactly one bubble.
- ID/EX register update, in priority order: rst; else StallX holds; else FlushE zeroes all fields including addresses; else it loads the D inputs.
- EX/MEM update: holds on StallX; otherwise it loads the E values.
- Forwarding (combinational, M beats W):
  - ForwardAE=10 if RegWriteM & RdM!=0 & RdM==Rs1E.
  - Else ForwardAE=01 if RegWriteW & RdW!=0 & RdW==Rs1E.
  - Else ForwardAE=00.
  - ForwardBE uses the same rules with Rs2E.
- Wait counter:
  - Increments each MemWait cycle, saturating at MAX_WAIT.
  - Clears on any cycle with MemWait=0.
  - MemErr sets on the edge where counter==MAX_WAIT and MemWait=1, and stays set until rst.
  - The pipe keeps stalling while MemErr is set. The controller does not abort the access.
- No added latency: control advances one stage per unstalled cycle, matching the datapath registers.

Test Plan:
- Reset and walk: rst 1 cycle, then feed RegWriteD=1, RdD=5, ALUControlD=3'b010. RegWriteE/RdE=5 appear after 1 edge, RegWriteM/RdM=5 after 2, RegWriteW/RdW=5 after 3. All stalls and flushes stay 0.
- Load-use: lw x6 in E (ResultSrcE=1, RdE=6) with Rs1D=6. Expect StallF=StallD=FlushE=1 for exactly 1 cycle, then ForwardAE=01 when the consumer reaches E.
- Forward priority: RegWriteM=1/RdM=7 and RegWriteW=1/RdW=7 with Rs1E=7 and Rs2E=7. Expect ForwardAE=ForwardBE=10. Repeat with RdM=0: expect 01.
- Branch over load-use: BranchE=1, ZeroE=1, and LoadUse condition true in the same cycle. Expect PCSrcE=FlushD=FlushE=1 and StallF=StallD=0.
- Memory wait: ResultSrcM=1, RegWriteM=1, MemReady=0 for 3 cycles. Expect StallX=StallF=StallD=1 and RegWriteW=0 for those cycles. E/M fields are unchanged. On MemReady=1, RegWriteW=1 on the next edge.
- Timeout: MAX_WAIT=15, MemReady held 0 for 17 cycles. Expect MemErr rises after the 16th wait cycle and stays 1 after MemReady returns. A rst mid-wait clears MemErr, the counter and all E/M/W fields on the next edge.
